// File: rtl/lisa_qspi_pkg.sv
// Shared widths and arbiter state encoding for the LISA QSPI arbiter slice.
package lisa_qspi_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  localparam int STRB_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_BEAT    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/lisa_qspi_arbiter_if.sv
// Link between the arbiter and the lisa_qqspi controller request/response port.
interface lisa_qspi_arbiter_if
  import lisa_qspi_pkg::*;
#(
  parameter int CHIP_SELECTS = 2
) ();

  logic [ADDR_W-1:0]       q_addr;
  logic [DATA_W-1:0]       q_wdata;
  logic [STRB_W-1:0]       q_wstrb;
  logic [LEN_W-1:0]        q_xfer_len;
  logic [CHIP_SELECTS-1:0] q_ce_ctrl;
  logic                    q_valid;
  logic                    q_ready_ack;
  logic                    q_ready;
  logic                    q_xfer_done;
  logic [DATA_W-1:0]       q_rdata;

  modport master (
    output q_addr, q_wdata, q_wstrb, q_xfer_len, q_ce_ctrl, q_valid, q_ready_ack,
    input  q_ready, q_xfer_done, q_rdata
  );

  modport slave (
    input  q_addr, q_wdata, q_wstrb, q_xfer_len, q_ce_ctrl, q_valid, q_ready_ack,
    output q_ready, q_xfer_done, q_rdata
  );

endinterface

// File: rtl/lisa_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module lisa_rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned j;
    logic        found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
    any = found;
  end

endmodule

// File: rtl/lisa_qspi_arbiter.sv
// Round-robin arbiter sharing one lisa_qqspi controller among NREQ burst requesters.
module lisa_qspi_arbiter
  import lisa_qspi_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int CHIP_SELECTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*ADDR_W-1:0]       req_addr,
  input  logic [NREQ*DATA_W-1:0]       req_wdata,
  input  logic [NREQ*STRB_W-1:0]       req_wstrb,
  input  logic [NREQ*LEN_W-1:0]        req_len,
  input  logic [NREQ*CHIP_SELECTS-1:0] req_cs,
  input  logic [NREQ-1:0]              req_wack,
  output logic [NREQ-1:0]              rsp_ready,
  output logic [NREQ-1:0]              rsp_done,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [NREQ-1:0]              grant,
  lisa_qspi_arbiter_if.master          q
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t              state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        gidx;
  logic [LEN_W-1:0]        len_l;
  logic [CHIP_SELECTS-1:0] cs_l;
  logic [STRB_W-1:0]       wstrb_l;
  logic                    q_valid_r;
  logic                    q_ready_d;
  logic                    q_rise;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  lisa_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign q_rise = q.q_ready & ~q_ready_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      len_l     <= '0;
      cs_l      <= '0;
      wstrb_l   <= '0;
      q_valid_r <= 1'b0;
      q_ready_d <= 1'b0;
      rsp_ready <= '0;
      rsp_done  <= '0;
      rsp_rdata <= '0;
    end else begin
      q_ready_d <= q.q_ready;
      rsp_ready <= '0;
      rsp_done  <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any && !q.q_ready) begin
            grant     <= pick_onehot;
            gidx      <= pick_idx;
            len_l     <= req_len[pick_idx*LEN_W +: LEN_W];
            cs_l      <= req_cs[pick_idx*CHIP_SELECTS +: CHIP_SELECTS];
            wstrb_l   <= req_wstrb[pick_idx*STRB_W +: STRB_W];
            q_valid_r <= 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: state <= ARB_BEAT;
        ARB_BEAT: begin
          if (q_rise) begin
            rsp_ready <= grant;
            rsp_rdata <= q.q_rdata;
          end
          // Requester's own valid is not consulted here: the controller cannot abort a burst.
          if (q.q_xfer_done) begin
            rsp_done  <= grant;
            q_valid_r <= 1'b0;
            state     <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          if (!q.q_ready) begin
            ptr   <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
            grant <= '0;
            cs_l  <= '0;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign q.q_valid     = q_valid_r;
  assign q.q_addr      = req_addr[gidx*ADDR_W +: ADDR_W];
  assign q.q_wdata     = req_wdata[gidx*DATA_W +: DATA_W];
  assign q.q_wstrb     = req_wstrb[gidx*STRB_W +: STRB_W];
  assign q.q_xfer_len  = len_l;
  assign q.q_ce_ctrl   = cs_l;
  assign q.q_ready_ack = (state == ARB_BEAT) & (|wstrb_l) & q.q_ready & req_wack[gidx];

endmodule

// File: tb/tb_lisa_qspi_arbiter.sv
// Directed bench for lisa_qspi_arbiter with a behavioural lisa_qqspi responder.
module tb_lisa_qspi_arbiter;

  localparam int NREQ = 3;
  localparam int CS   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*24-1:0] req_addr;
  logic [NREQ*16-1:0] req_wdata;
  logic [NREQ*2-1:0]  req_wstrb;
  logic [NREQ*4-1:0]  req_len;
  logic [NREQ*CS-1:0] req_cs;
  logic [NREQ-1:0] req_wack;
  logic [NREQ-1:0] rsp_ready;
  logic [NREQ-1:0] rsp_done;
  logic [15:0]     rsp_rdata;
  logic [NREQ-1:0] grant;

  lisa_qspi_arbiter_if #(.CHIP_SELECTS(CS)) qif ();

  lisa_qspi_arbiter #(.NREQ(NREQ), .CHIP_SELECTS(CS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_len   (req_len),
    .req_cs    (req_cs),
    .req_wack  (req_wack),
    .rsp_ready (rsp_ready),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .grant     (grant),
    .q         (qif)
  );

  always #5 clk = ~clk;

  // Controller model: 2-cycle gap per beat, reads hold ready 1 cycle with xfer_done on
  // the last beat, writes hold ready until ready_ack then pulse xfer_done.
  typedef enum {M_IDLE, M_GAP, M_READY, M_DONE} m_t;
  m_t          ms;
  logic [3:0]  beats_left;
  logic [15:0] beat_no;
  logic [15:0] rdata_base;
  int          gap, wcnt;
  logic        wr, wack;

  assign req_wack = {NREQ{wack}};

  always @(posedge clk) begin
    if (!rst_n) begin
      ms <= M_IDLE; qif.q_ready <= 1'b0; qif.q_xfer_done <= 1'b0; qif.q_rdata <= '0;
      wack <= 1'b0; beats_left <= '0; beat_no <= '0; gap <= 0; wr <= 1'b0; wcnt <= 0;
    end else begin
      case (ms)
        M_IDLE: if (qif.q_valid) begin
          beats_left <= qif.q_xfer_len; beat_no <= '0; wr <= |qif.q_wstrb; gap <= 2; ms <= M_GAP;
        end
        M_GAP: if (gap == 0) begin
          qif.q_ready <= 1'b1; qif.q_rdata <= rdata_base + beat_no; wcnt <= 0;
          if (!wr && beats_left == 0) qif.q_xfer_done <= 1'b1;
          ms <= M_READY;
        end else gap <= gap - 1;
        M_READY: begin
          qif.q_xfer_done <= 1'b0;
          if (!wr || qif.q_ready_ack) begin
            qif.q_ready <= 1'b0; wack <= 1'b0; beat_no <= beat_no + 16'd1;
            if (beats_left == 0) begin
              if (wr) qif.q_xfer_done <= 1'b1;
              ms <= M_DONE;
            end else begin
              beats_left <= beats_left - 4'd1; gap <= 2; ms <= M_GAP;
            end
          end else if (wcnt == 4) wack <= 1'b1;
          else wcnt <= wcnt + 1;
        end
        M_DONE: begin
          qif.q_xfer_done <= 1'b0;
          if (!qif.q_valid) ms <= M_IDLE;
        end
      endcase
    end
  end

  // Monitor: per-requester pulse counts, grant order log and protocol-rule violations.
  int          rdy_cnt [NREQ];
  int          done_cnt[NREQ];
  int          ack_cnt = 0;
  int          viol    = 0;
  logic [15:0] last_rdata = '0;
  logic [NREQ-1:0] grant_prev = '0;
  int          glog[$];

  initial for (int i = 0; i < NREQ; i++) begin rdy_cnt[i] = 0; done_cnt[i] = 0; end

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_ready[i]) rdy_cnt[i]++;
      if (rsp_done[i])  done_cnt[i]++;
      if (grant[i] && grant_prev == '0) glog.push_back(i);
    end
    if (|rsp_ready) last_rdata = rsp_rdata;
    if (qif.q_ready_ack) ack_cnt++;
    if (!$onehot0(grant)) viol++;
    if ((rsp_ready & ~grant) != '0 || (rsp_done & ~grant) != '0) viol++;
    if (grant_prev != '0 && grant != '0 && grant != grant_prev) viol++;
    if (qif.q_ready_ack && (!wack || qif.q_wstrb == 2'b00)) viol++;
    grant_prev = grant;
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_qvalid(input string tag);
    int n = 0;
    while (!qif.q_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, " q_valid timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_ready(input int idx, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rsp_ready[idx] && n < 500);
    check({tag, " rsp_ready timeout"}, 32'(n < 500), 32'd1);
  endtask

  // Count rsp_done pulses; drop each finisher's valid unless hold, dropping all at the end.
  task automatic service(input int n, input bit hold, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 3000) begin
      @(negedge clk); cyc++;
      for (int i = 0; i < NREQ; i++)
        if (rsp_done[i]) begin
          got++;
          if (!hold) req_valid[i] = 1'b0;
        end
      if (got >= n) req_valid = '0;
    end
    check({tag, " done count"}, 32'(got), 32'(n));
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int r0, d0, a0, g0, v0;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    req_len = '0; req_cs = '0; rdata_base = '0;
    repeat (3) @(negedge clk);
    check("rst grant",     32'(grant), 32'd0);
    check("rst q_valid",   32'(qif.q_valid), 32'd0);
    check("rst rsp_ready", 32'(rsp_ready), 32'd0);
    check("rst rsp_done",  32'(rsp_done), 32'd0);
    check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst ce_ctrl",   32'(qif.q_ce_ctrl), 32'd0);
    check("rst ready_ack", 32'(qif.q_ready_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read from requester 0
    req_addr[23:0] = 24'h000100; req_len[3:0] = 4'd0; req_wstrb[1:0] = 2'b00; req_cs[1:0] = 2'b01;
    rdata_base = 16'hBEEF;
    r0 = rdy_cnt[0]; d0 = done_cnt[0];
    req_valid = 3'b001;
    wait_qvalid("rd1");
    check("rd1 grant",    32'(grant), 32'b001);
    check("rd1 q_addr",   32'(qif.q_addr), 32'h000100);
    check("rd1 xfer_len", 32'(qif.q_xfer_len), 32'd0);
    check("rd1 ce_ctrl",  32'(qif.q_ce_ctrl), 32'b01);
    service(1, 1'b0, "rd1");
    check("rd1 rsp_ready cnt", 32'(rdy_cnt[0] - r0), 32'd1);
    check("rd1 rsp_done cnt",  32'(done_cnt[0] - d0), 32'd1);
    check("rd1 rdata",         32'(last_rdata), 32'hBEEF);
    check("rd1 grant idle",    32'(grant), 32'd0);

    // two simultaneous requesters from reset; second round starts at ptr=2 which wraps to 0
    reset_pulse();
    req_addr[47:24] = 24'h000200; req_len[7:4] = 4'd0; req_wstrb[3:2] = 2'b00; req_cs[3:2] = 2'b10;
    g0 = glog.size();
    req_valid = 3'b011;
    service(2, 1'b0, "rr1");
    check("rr1 first",  32'(glog[g0]), 32'd0);
    check("rr1 second", 32'(glog[g0+1]), 32'd1);
    g0 = glog.size();
    req_valid = 3'b011;
    service(2, 1'b0, "rr2");
    check("rr2 first",  32'(glog[g0]), 32'd0);
    check("rr2 second", 32'(glog[g0+1]), 32'd1);

    // write burst on requester 2, len=3, wack lags every beat by several cycles
    req_addr[71:48] = 24'h00ABCD; req_wdata[47:32] = 16'h5A5A; req_wstrb[5:4] = 2'b11;
    req_len[11:8] = 4'd3; req_cs[5:4] = 2'b10;
    r0 = rdy_cnt[2]; d0 = done_cnt[2]; a0 = ack_cnt; v0 = viol;
    req_valid = 3'b100;
    wait_qvalid("wr");
    check("wr grant",    32'(grant), 32'b100);
    check("wr q_addr",   32'(qif.q_addr), 32'h00ABCD);
    check("wr q_wdata",  32'(qif.q_wdata), 32'h5A5A);
    check("wr q_wstrb",  32'(qif.q_wstrb), 32'b11);
    check("wr xfer_len", 32'(qif.q_xfer_len), 32'd3);
    check("wr ce_ctrl",  32'(qif.q_ce_ctrl), 32'b10);
    service(1, 1'b0, "wr");
    check("wr rsp_ready cnt", 32'(rdy_cnt[2] - r0), 32'd4);
    check("wr rsp_done cnt",  32'(done_cnt[2] - d0), 32'd1);
    check("wr ack cnt",       32'(ack_cnt - a0), 32'd4);
    check("wr violations",    32'(viol - v0), 32'd0);

    // requester 1 drops valid mid-burst while requester 0 starts waiting
    req_len[7:4] = 4'd2; rdata_base = 16'h1000;
    r0 = rdy_cnt[1]; d0 = done_cnt[1]; g0 = glog.size();
    req_valid = 3'b010;
    wait_ready(1, "drop");
    req_valid = 3'b001;
    service(2, 1'b0, "drop");
    check("drop rsp_ready cnt", 32'(rdy_cnt[1] - r0), 32'd3);
    check("drop rsp_done cnt",  32'(done_cnt[1] - d0), 32'd1);
    check("drop grant count",   32'(glog.size() - g0), 32'd2);
    check("drop order 0",       32'(glog[g0]), 32'd1);
    check("drop order 1",       32'(glog[g0+1]), 32'd0);
    check("drop rdata",         32'(last_rdata), 32'h1000);

    // all three continuously valid for nine bursts from reset
    reset_pulse();
    req_len = '0; req_wstrb = '0;
    g0 = glog.size();
    req_valid = 3'b111;
    service(9, 1'b1, "fair");
    check("fair grant count", 32'(glog.size() - g0), 32'd9);
    for (int i = 0; i < 9; i++) check($sformatf("fair order %0d", i), 32'(glog[g0+i]), 32'(i % 3));

    // reset during BEAT, then a clean read
    req_len[3:0] = 4'd3; rdata_base = 16'h4000;
    req_valid = 3'b001;
    wait_ready(0, "mrst");
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst q_valid",   32'(qif.q_valid), 32'd0);
    check("mrst grant",     32'(grant), 32'd0);
    check("mrst rsp_ready", 32'(rsp_ready), 32'd0);
    check("mrst rsp_done",  32'(rsp_done), 32'd0);
    check("mrst rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("mrst ce_ctrl",   32'(qif.q_ce_ctrl), 32'd0);
    req_len[3:0] = 4'd0; rdata_base = 16'h1234;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt[0];
    service(1, 1'b0, "post");
    check("post rsp_done cnt", 32'(done_cnt[0] - d0), 32'd1);
    check("post rdata",        32'(last_rdata), 32'h1234);

    check("protocol violations", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
